operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Parametrised register-read stage between fetch/decode and execute.
//  - Register file with NUM_WB writeback ports and same-cycle bypass.
//  - Per-register pending-write scoreboard that holds issue on RAW/WAW hazards.
//  - Full-format immediate generation with an illegal-opcode flag.
//  - One output pipeline register with valid/ready handshake plus flush and stall.
// PARAMETERS
//  XLEN    32  data/register width (>=32; immediates sign-extend to XLEN)
//  NREGS   32  architectural registers (16 for RV32E); addresses >=NREGS are illegal
//  NUM_WB  2   writeback ports; higher index has priority
//  CNT_W   2   pending counter width per register; max in-flight writes per rd = 2^CNT_W-1
// PORTS
//  clk      in   1             clock, all state on posedge
//  rst      in   1             synchronous, active-high reset
//  v_in     in   1             upstream instruction valid
//  r_out    out  1             ready to accept upstream (combinational)
//  ir_in    in   32            instruction
//  pc_in    in   XLEN          its PC
//  wb_v     in   NUM_WB        per-port writeback valid
//  wb_addr  in   5*NUM_WB      per-port rd, port i at [5i+:5]
//  wb_data  in   XLEN*NUM_WB   per-port data, port i at [XLEN*i+:XLEN]
//  kill_v   in   1             downstream squashed an issued instruction that writes rd
//  kill_rd  in   5             rd of squashed instruction
//  flush    in   1             discard the held instruction
//  stall    in   1             block acceptance this cycle
//  v_out    out  1             output valid
//  r_in     in   1             downstream ready
//  ir_out   out  32            held instruction
//  pc_out   out  XLEN          held PC
//  a_out    out  XLEN          rs1 operand
//  b_out    out  XLEN          rs2 operand
//  i_out    out  XLEN          immediate
//  ill_out  out  1             held opcode is unrecognised, or a register address is >=NREGS
// BEHAVIOUR
//  Reset
//  - All registers, outputs, regfile entries and pending counters go to 0.
//  - r_out is 0 only while rst is high.
//  Handshake
//  - Accept when v_in&&r_out.
//  - r_out = !rst && !stall && !hazard && (!v_out || r_in).
//  - Drain when v_out&&r_in.
//  - Accept with no drain sets v_out=1; drain with no accept clears it.
//  - Latency is 1 cycle, with full throughput when there are no hazards.
//  - Outputs stay stable while v_out&&!r_in.
//  Flush
//  - Same-cycle flush clears v_out and blocks acceptance (r_out forced to 0).
//  - If the held instruction writes rd, its counter is decremented.
//  Writes-rd
//  - Opcode in {LUI, AUIPC, JAL, JALR, LOAD, IM_ALU, ALU} and rd!=0.
//  - rs1 used unless LUI/AUIPC/JAL; rs2 used only for BRANCH/STORE/ALU.
//  Regfile and bypass
//  - Port i writes when wb_v[i] && wb_addr!=0; when ports collide, the highest i wins.
//  - A read of r0 returns 0; a read of an unused source returns 0.
//  - A source matching a same-cycle WB address takes the highest-priority wb_data.
//  Scoreboard (cnt[r])
//  - Next value = cnt + issue_inc - (#WB ports hitting r) - kill_hit - flush_hit.
//  - issue_inc = 1 on accept of a writes-rd instruction.
//  - Decrement saturates at 0; r0 is never tracked.
//  Hazard (checked against current-cycle cnt)
//  - Used source s with cnt[s] > (number of WB ports writing s this cycle).
//  - Or writes-rd with cnt[rd] == 2^CNT_W-1.
//  Immediates
//  - I/S/B/J formats sign-extended to XLEN.
//  - U format is {ir[31:12],12'b0}, sign-extended to XLEN.
//  - Shift-immediate is zero-extended ir[24:20].
//  - Unknown opcode gives i_out=0 and ill_out=1.
// TESTING
//  - Reset: rst=1 for 2 cycles with v_in=1 -> v_out=0, r_out=0, a_out=b_out=0; then r_out=1.
//  - Back-to-back: ADDI x1,x0,5 then ADD x2,x0,x0, r_in=1 -> v_out=1 for 2 consecutive cycles, i_out=5.
//  - RAW stall: issue ADDI x3; next ADD x4,x3,x3 -> r_out=0 until wb_v[0], addr=3, data=0x1234.
//    That same cycle, accept with a_out=b_out=0x1234 and cnt[3]=0.
//  - WB collision: port0 x5=0xA and port1 x5=0xB, both valid -> regfile x5=0xB; bypassed read gives 0xB.
//    Any write to x0 -> a read of x0 returns 0.
//  - Backpressure and flush: v_out=1, r_in=0 for 3 cycles -> outputs held, r_out=0.
//    Then flush holding ADDI x6 -> v_out=0 next cycle, cnt[6] back to 0.
//  - WAW saturation (CNT_W=2): issue 3 writes to x7 with no WB -> 4th blocked.
//    kill_v with kill_rd=7 -> the 4th is accepted next cycle.

Source files
------------

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage: regfile with bypass, pending-write scoreboard, immediates, output register
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_WB = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     v_in,
    output logic                     r_out,
    input  logic [31:0]              ir_in,
    input  logic [XLEN-1:0]          pc_in,
    input  logic [NUM_WB-1:0]        wb_v,
    input  logic [5*NUM_WB-1:0]      wb_addr,
    input  logic [XLEN*NUM_WB-1:0]   wb_data,
    input  logic                     kill_v,
    input  logic [4:0]               kill_rd,
    input  logic                     flush,
    input  logic                     stall,
    output logic                     v_out,
    input  logic                     r_in,
    output logic [31:0]              ir_out,
    output logic [XLEN-1:0]          pc_out,
    output logic [XLEN-1:0]          a_out,
    output logic [XLEN-1:0]          b_out,
    output logic [XLEN-1:0]          i_out,
    output logic                     ill_out
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IM_ALU = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Storage is always 32 deep so 5-bit addresses index it directly; entries >= NREGS stay 0.
    logic [XLEN-1:0]  rf      [32];
    logic [CNT_W-1:0] cnt     [32];
    logic [CNT_W-1:0] cnt_nxt [32];

    logic             held_wr;
    logic [4:0]       held_rd;

    logic [6:0]       opc;
    logic [4:0]       rd, rs1, rs2;
    logic [2:0]       f3;
    logic             known, wr, use1, use2, writes_rd, ill;
    logic [XLEN-1:0]  imm, a_nxt, b_nxt;
    int               hits1, hits2;
    logic             hazard, accept, drain;

    assign opc = ir_in[6:0];
    assign rd  = ir_in[11:7];
    assign f3  = ir_in[14:12];
    assign rs1 = ir_in[19:15];
    assign rs2 = ir_in[24:20];

    function automatic int wb_hits(input logic [NUM_WB-1:0] v, input logic [5*NUM_WB-1:0] a,
                                   input logic [4:0] r);
        int n;
        n = 0;
        for (int i = 0; i < NUM_WB; i++)
            if (v[i] && a[5*i+:5] == r && r != 5'd0) n++;
        return n;
    endfunction

    always_comb begin
        known = 1'b1;
        wr    = 1'b0;
        use1  = 1'b0;
        use2  = 1'b0;
        imm   = '0;
        case (opc)
            OP_LUI, OP_AUIPC: begin
                wr = 1'b1;
                imm = {XLEN{ir_in[31]}};
                imm[31:0] = {ir_in[31:12], 12'b0};
            end
            OP_JAL: begin
                wr = 1'b1;
                imm = {XLEN{ir_in[31]}};
                imm[20:0] = {ir_in[31], ir_in[19:12], ir_in[20], ir_in[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD: begin
                wr = 1'b1;
                use1 = 1'b1;
                imm = {XLEN{ir_in[31]}};
                imm[11:0] = ir_in[31:20];
            end
            OP_IM_ALU: begin
                wr = 1'b1;
                use1 = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm[4:0] = ir_in[24:20];
                end else begin
                    imm = {XLEN{ir_in[31]}};
                    imm[11:0] = ir_in[31:20];
                end
            end
            OP_ALU: begin
                wr = 1'b1;
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
                imm = {XLEN{ir_in[31]}};
                imm[12:0] = {ir_in[31], ir_in[7], ir_in[30:25], ir_in[11:8], 1'b0};
            end
            OP_STORE: begin
                use1 = 1'b1;
                use2 = 1'b1;
                imm = {XLEN{ir_in[31]}};
                imm[11:0] = {ir_in[31:25], ir_in[11:7]};
            end
            default: known = 1'b0;
        endcase
    end

    assign writes_rd = wr && rd != 5'd0;
    assign ill = !known || (use1 && int'(rs1) >= NREGS) || (use2 && int'(rs2) >= NREGS)
                        || (wr && int'(rd) >= NREGS);

    // Operand read with bypass: ascending port order lets the highest port win.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        if (use1 && rs1 != 5'd0 && int'(rs1) < NREGS) a_nxt = rf[rs1];
        if (use2 && rs2 != 5'd0 && int'(rs2) < NREGS) b_nxt = rf[rs2];
        for (int i = 0; i < NUM_WB; i++) begin
            if (use1 && wb_v[i] && wb_addr[5*i+:5] == rs1 && rs1 != 5'd0) a_nxt = wb_data[XLEN*i+:XLEN];
            if (use2 && wb_v[i] && wb_addr[5*i+:5] == rs2 && rs2 != 5'd0) b_nxt = wb_data[XLEN*i+:XLEN];
        end
    end

    assign hits1  = wb_hits(wb_v, wb_addr, rs1);
    assign hits2  = wb_hits(wb_v, wb_addr, rs2);
    assign hazard = (use1 && int'(cnt[rs1]) > hits1) || (use2 && int'(cnt[rs2]) > hits2)
                 || (writes_rd && cnt[rd] == CNT_MAX);

    assign r_out  = !rst && !stall && !flush && !hazard && (!v_out || r_in);
    assign accept = v_in && r_out;
    assign drain  = v_out && r_in;

    always_comb begin
        int n;
        n = 0;
        cnt_nxt = '{default: '0};
        for (int r = 1; r < 32; r++) begin
            n = int'(cnt[r]);
            if (accept && writes_rd && rd == 5'(r)) n = n + 1;
            n = n - wb_hits(wb_v, wb_addr, 5'(r));
            if (kill_v && kill_rd == 5'(r)) n = n - 1;
            if (flush && v_out && held_wr && held_rd == 5'(r)) n = n - 1;
            if (n < 0) n = 0;
            cnt_nxt[r] = CNT_W'(n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_out   <= 1'b0;
            ir_out  <= '0;
            pc_out  <= '0;
            a_out   <= '0;
            b_out   <= '0;
            i_out   <= '0;
            ill_out <= 1'b0;
            held_wr <= 1'b0;
            held_rd <= '0;
            for (int r = 0; r < 32; r++) begin
                rf[r]  <= '0;
                cnt[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WB; i++)
                if (wb_v[i] && wb_addr[5*i+:5] != 5'd0 && int'(wb_addr[5*i+:5]) < NREGS)
                    rf[wb_addr[5*i+:5]] <= wb_data[XLEN*i+:XLEN];
            for (int r = 0; r < 32; r++)
                cnt[r] <= cnt_nxt[r];
            if (flush) begin
                v_out <= 1'b0;
            end else if (accept) begin
                v_out   <= 1'b1;
                ir_out  <= ir_in;
                pc_out  <= pc_in;
                a_out   <= a_nxt;
                b_out   <= b_nxt;
                i_out   <= imm;
                ill_out <= ill;
                held_wr <= writes_rd;
                held_rd <= rd;
            end else if (drain) begin
                v_out <= 1'b0;
            end
        end
    end

endmodule
